// File: rtl/serial_word_comparator.sv
// Bit-serial unsigned magnitude/equality comparator: two MSB-first words arrive
// one bit per accepted beat; a registered eq/gt/lt verdict is produced with a done pulse.
module serial_word_comparator #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          bit_a,
    input  logic          bit_b,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic [CW-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] bit_count_r, count_next_s;
    logic          decided_r, decided_next_s;
    logic          gt_prov_r, gt_prov_next_s;
    logic [2:0]    verdict_r, verdict_next_s;
    logic          busy_r, done_r;

    // Next-state, beat acceptance and verdict capture
    always_comb begin
        state_next_s   = state_r;
        count_next_s   = bit_count_r;
        decided_next_s = decided_r;
        gt_prov_next_s = gt_prov_r;
        verdict_next_s = verdict_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s   = SHIFT;
                    count_next_s   = '0;
                    decided_next_s = 1'b0;
                    gt_prov_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                // A restart wins over a beat presented in the same cycle
                if (start) begin
                    state_next_s   = SHIFT;
                    count_next_s   = '0;
                    decided_next_s = 1'b0;
                    gt_prov_next_s = 1'b0;
                end else if (bit_valid) begin
                    count_next_s = bit_count_r + CW'(1);
                    if (!decided_r && (bit_a != bit_b)) begin
                        decided_next_s = 1'b1;
                        gt_prov_next_s = bit_a & ~bit_b;
                    end else begin
                        decided_next_s = decided_r;
                    end
                    if (count_next_s == CW'(WIDTH)) begin
                        state_next_s   = DONE;
                        verdict_next_s = {~decided_next_s,
                                          decided_next_s & gt_prov_next_s,
                                          decided_next_s & ~gt_prov_next_s};
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s   = SHIFT;
                    count_next_s   = '0;
                    decided_next_s = 1'b0;
                    gt_prov_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s   = IDLE;
                count_next_s   = '0;
                decided_next_s = 1'b0;
                gt_prov_next_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_count_r <= '0;
            decided_r   <= 1'b0;
            gt_prov_r   <= 1'b0;
            verdict_r   <= 3'b000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bit_count_r <= count_next_s;
            decided_r   <= decided_next_s;
            gt_prov_r   <= gt_prov_next_s;
            verdict_r   <= verdict_next_s;
            busy_r      <= (state_next_s == SHIFT);
            done_r      <= (state_next_s == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign eq        = verdict_r[2];
    assign gt        = verdict_r[1];
    assign lt        = verdict_r[0];
    assign bit_count = bit_count_r;

endmodule
